if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. It owns the PC and fetches from a variable-latency instruction memory over a req/ack handshake. It holds one fetched word in a skid buffer and drives the IF/ID register (`D_IR`, `D_NPC`). It applies branch/jump redirects resolved in decode, with MIPS delay-slot semantics: the delay slot always executes.

---
 rtl/if_stage.sv | 152 +++++++++++++++
 tb/tb_if_stage.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the five-stage MIPS pipeline.
// Owns the PC and fetches over a req/ack handshake (at most one request in
// flight). One fetched word can be parked in a skid buffer while decode
// stalls. Branch/jump redirects from decode honour the MIPS delay slot.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   stall             decode hazard hold; IF/ID register holds while 1
//   Branch/BranchAddr redirect request and target from decode
//   imem_req/addr     fetch request and address (stable while req=1)
//   imem_ack/rdata    transfer completion and instruction word
//   D_IR/D_NPC        IF/ID register: instruction (0 = bubble) and addr+4
//   D_valid           IF/ID holds a real instruction
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        Branch,
  input  logic [31:0] BranchAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] D_IR,
  output logic [31:0] D_NPC,
  output logic        D_valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   buf_ir;
  logic [XLEN-1:0]   buf_npc;
  logic              redir_v;
  logic [XLEN-1:0]   redir_addr;
  logic              squash;

  logic              xfer_c;
  logic              taken_c;
  logic              case_a_c;
  logic              case_b_c;
  logic [XLEN-1:0]   pc_inc_c;

  // Request and address come straight from the state and PC flops.
  assign imem_req  = (state == ST_REQ);
  assign imem_addr = pc;

  // Transfer, branch-taken and delay-slot position decode.
  assign xfer_c   = (state == ST_REQ) && imem_ack;
  assign taken_c  = D_valid && !stall && Branch;
  assign pc_inc_c = pc + XLEN'(4);
  // Case A: delay slot not yet transferred; case B: delay slot already fetched.
  assign case_a_c = taken_c && (pc == D_NPC);
  assign case_b_c = taken_c && (pc == (D_NPC + XLEN'(4)));

  // Fetch FSM, PC, skid buffer, redirect bookkeeping and IF/ID register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      buf_ir     <= '0;
      buf_npc    <= '0;
      redir_v    <= 1'b0;
      redir_addr <= '0;
      squash     <= 1'b0;
      D_IR       <= '0;
      D_NPC      <= '0;
      D_valid    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state <= ST_REQ;
        end

        ST_REQ: begin
          if (xfer_c) begin
            if (squash || case_b_c) begin
              // Word past the delay slot: discard and jump.
              pc      <= case_b_c ? BranchAddr : redir_addr;
              squash  <= 1'b0;
              redir_v <= 1'b0;
              if (!stall) begin
                D_IR    <= '0;
                D_valid <= 1'b0;
              end
            end else begin
              if (!stall) begin
                D_IR    <= imem_rdata;
                D_NPC   <= pc_inc_c;
                D_valid <= 1'b1;
              end else begin
                buf_ir  <= imem_rdata;
                buf_npc <= pc_inc_c;
                state   <= ST_FULL;
              end
              // Delay slot completing: the next fetch follows any redirect.
              if (case_a_c) begin
                pc <= BranchAddr;
              end else if (redir_v) begin
                pc <= redir_addr;
              end else begin
                pc <= pc_inc_c;
              end
              redir_v <= 1'b0;
            end
          end else begin
            if (!stall) begin
              D_IR    <= '0;
              D_valid <= 1'b0;
            end
            // Request must stay stable, so the redirect is remembered instead.
            if (case_a_c) begin
              redir_v    <= 1'b1;
              redir_addr <= BranchAddr;
            end else if (case_b_c) begin
              squash     <= 1'b1;
              redir_v    <= 1'b1;
              redir_addr <= BranchAddr;
            end
          end
        end

        ST_FULL: begin
          if (!stall) begin
            D_IR    <= buf_ir;
            D_NPC   <= buf_npc;
            D_valid <= 1'b1;
            state   <= ST_REQ;
            // Buffered word is the delay slot; no fetch is in flight.
            if (case_b_c) begin
              pc <= BranchAddr;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a variable-latency memory model answers
// requests, expected fetch addresses and decoded IF/ID words are queued per
// scenario and compared as the DUT transfers and decode consumes them.
module tb_if_stage;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        Branch;
  logic [31:0] BranchAddr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] D_IR;
  logic [31:0] D_NPC;
  logic        D_valid;

  int checks;
  int failures;
  int lat;
  int wait_cnt;
  logic        br_en;
  logic [31:0] br_pc;
  logic [31:0] br_tgt;

  logic [31:0] exp_fetch[$];
  logic [63:0] exp_dec[$];

  if_stage #(.RESET_PC(RPC)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .Branch     (Branch),
    .BranchAddr (BranchAddr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .D_IR       (D_IR),
    .D_NPC      (D_NPC),
    .D_valid    (D_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic push_dec(input logic [31:0] a);
    exp_dec.push_back({mem_word(a), a + 32'd4});
  endtask

  // One cycle: memory model + decode model drive inputs, scoreboard compares,
  // then advance to 1 time unit after the next rising edge.
  task automatic step();
    logic        xfer;
    logic        req_pre;
    logic [31:0] ef;
    logic [63:0] ed;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    if (imem_req && wait_cnt >= lat) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end
    Branch     = D_valid && br_en && (D_IR == mem_word(br_pc));
    BranchAddr = br_tgt;
    req_pre    = imem_req;
    xfer       = imem_req && imem_ack;
    if (xfer && exp_fetch.size() > 0) begin
      ef = exp_fetch.pop_front();
      checks++;
      if (imem_addr !== ef) begin
        failures++;
        $display("FAIL fetch_order: imem_addr got %h want %h", imem_addr, ef);
      end
    end
    if (D_valid && !stall && exp_dec.size() > 0) begin
      ed = exp_dec.pop_front();
      checks++;
      if ({D_IR, D_NPC} !== ed) begin
        failures++;
        $display("FAIL decode_seq: D_IR/D_NPC got %h/%h want %h/%h",
                 D_IR, D_NPC, ed[63:32], ed[31:0]);
      end
    end
    @(posedge clk);
    #1;
    if (xfer) wait_cnt = 0;
    else if (req_pre) wait_cnt++;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_fetch.size() + exp_dec.size()) > 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if ((exp_fetch.size() + exp_dec.size()) != 0) begin
      failures++;
      $display("FAIL %s_drain: fetch left %0d decode left %0d, want 0 0",
               name, exp_fetch.size(), exp_dec.size());
    end
  endtask

  // Reset for two edges, release just after an edge; DUT is then in IDLE.
  task automatic do_reset();
    rst        = 1'b0;
    stall      = 1'b0;
    br_en      = 1'b0;
    br_pc      = 32'h0;
    br_tgt     = 32'h0;
    lat        = 0;
    wait_cnt   = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    Branch     = 1'b0;
    BranchAddr = 32'h0;
    exp_fetch.delete();
    exp_dec.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    stall      = 1'b0;
    br_en      = 1'b0;
    Branch     = 1'b0;
    BranchAddr = 32'h0;
    lat        = 0;
    wait_cnt   = 0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== RPC || D_IR !== 32'h0 ||
        D_NPC !== 32'h0 || D_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: req=%b addr=%h ir=%h npc=%h v=%b want 0 %h 0 0 0",
               imem_req, imem_addr, D_IR, D_NPC, D_valid, RPC);
    end
    rst = 1'b1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_req: imem_req got %b want 0", imem_req);
    end
    // Ack held high in IDLE must not be taken as a transfer.
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RPC || D_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_req: req=%b addr=%h v=%b want 1 %h 0",
               imem_req, imem_addr, D_valid, RPC);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    foreach (exp_fetch[i]) exp_fetch.delete(i);
    exp_fetch.push_back(32'h3000);
    exp_fetch.push_back(32'h3004);
    exp_fetch.push_back(32'h3008);
    exp_fetch.push_back(32'h300C);
    push_dec(32'h3000);
    push_dec(32'h3004);
    push_dec(32'h3008);
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || D_valid !== 1'b0) begin
      failures++;
      $display("FAIL zw_c1: req=%b addr=%h v=%b want 1 3000 0", imem_req, imem_addr, D_valid);
    end
    step();
    checks++;
    if (imem_addr !== 32'h3004 || D_NPC !== 32'h3004 || D_valid !== 1'b1) begin
      failures++;
      $display("FAIL zw_c2: addr=%h npc=%h v=%b want 3004 3004 1", imem_addr, D_NPC, D_valid);
    end
    step();
    checks++;
    if (imem_addr !== 32'h3008 || D_NPC !== 32'h3008) begin
      failures++;
      $display("FAIL zw_c3: addr=%h npc=%h want 3008 3008", imem_addr, D_NPC);
    end
    drain("zero_wait", 20);
  endtask

  task automatic test_ack_wait();
    do_reset();
    lat = 3;
    exp_fetch.push_back(32'h3000);
    exp_fetch.push_back(32'h3004);
    push_dec(32'h3000);
    push_dec(32'h3004);
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || D_valid !== 1'b0 || D_IR !== 32'h0) begin
        failures++;
        $display("FAIL wait_bubble%0d: req=%b addr=%h v=%b ir=%h want 1 3000 0 0",
                 i, imem_req, imem_addr, D_valid, D_IR);
      end
      step();
    end
    checks++;
    if (D_valid !== 1'b1 || D_IR !== mem_word(32'h3000) || D_NPC !== 32'h3004) begin
      failures++;
      $display("FAIL wait_load: v=%b ir=%h npc=%h want 1 %h 3004",
               D_valid, D_IR, D_NPC, mem_word(32'h3000));
    end
    drain("ack_wait", 40);
  endtask

  task automatic test_stall();
    do_reset();
    exp_fetch.push_back(32'h3000);
    exp_fetch.push_back(32'h3004);
    exp_fetch.push_back(32'h3008);
    exp_fetch.push_back(32'h300C);
    push_dec(32'h3000);
    push_dec(32'h3004);
    push_dec(32'h3008);
    push_dec(32'h300C);
    repeat (3) step();
    stall = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b0 || D_IR !== mem_word(32'h3004) || D_NPC !== 32'h3008 || D_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_full: req=%b ir=%h npc=%h v=%b want 0 %h 3008 1",
               imem_req, D_IR, D_NPC, D_valid, mem_word(32'h3004));
    end
    step();
    step();
    checks++;
    if (imem_req !== 1'b0 || D_IR !== mem_word(32'h3004)) begin
      failures++;
      $display("FAIL stall_hold: req=%b ir=%h want 0 %h", imem_req, D_IR, mem_word(32'h3004));
    end
    stall = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h300C || D_IR !== mem_word(32'h3008) ||
        D_NPC !== 32'h300C) begin
      failures++;
      $display("FAIL stall_release: req=%b addr=%h ir=%h npc=%h want 1 300c %h 300c",
               imem_req, imem_addr, D_IR, D_NPC, mem_word(32'h3008));
    end
    drain("stall", 20);
  endtask

  task automatic test_branch_slot();
    do_reset();
    br_en  = 1'b1;
    br_pc  = 32'h3000;
    br_tgt = 32'h3100;
    exp_fetch.push_back(32'h3000);
    exp_fetch.push_back(32'h3004);
    exp_fetch.push_back(32'h3100);
    exp_fetch.push_back(32'h3104);
    push_dec(32'h3000);
    push_dec(32'h3004);
    push_dec(32'h3100);
    repeat (3) step();
    checks++;
    if (imem_addr !== 32'h3100 || D_IR !== mem_word(32'h3004)) begin
      failures++;
      $display("FAIL branch_a: addr=%h ir=%h want 3100 %h", imem_addr, D_IR, mem_word(32'h3004));
    end
    drain("branch_slot", 20);
  endtask

  task automatic test_branch_redir();
    do_reset();
    lat    = 2;
    br_en  = 1'b1;
    br_pc  = 32'h3000;
    br_tgt = 32'h3100;
    exp_fetch.push_back(32'h3000);
    exp_fetch.push_back(32'h3004);
    exp_fetch.push_back(32'h3100);
    push_dec(32'h3000);
    push_dec(32'h3004);
    push_dec(32'h3100);
    repeat (5) step();
    checks++;
    if (D_valid !== 1'b0 || D_IR !== 32'h0 || imem_addr !== 32'h3004) begin
      failures++;
      $display("FAIL redir_pending: v=%b ir=%h addr=%h want 0 0 3004", D_valid, D_IR, imem_addr);
    end
    repeat (2) step();
    checks++;
    if (imem_addr !== 32'h3100 || D_IR !== mem_word(32'h3004)) begin
      failures++;
      $display("FAIL redir_jump: addr=%h ir=%h want 3100 %h", imem_addr, D_IR, mem_word(32'h3004));
    end
    drain("branch_redir", 40);
  endtask

  task automatic test_branch_full();
    do_reset();
    br_en  = 1'b1;
    br_pc  = 32'h3000;
    br_tgt = 32'h3100;
    exp_fetch.push_back(32'h3000);
    exp_fetch.push_back(32'h3004);
    exp_fetch.push_back(32'h3100);
    exp_fetch.push_back(32'h3104);
    push_dec(32'h3000);
    push_dec(32'h3004);
    push_dec(32'h3100);
    repeat (2) step();
    stall = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b0 || D_IR !== mem_word(32'h3000)) begin
      failures++;
      $display("FAIL bfull_hold: req=%b ir=%h want 0 %h", imem_req, D_IR, mem_word(32'h3000));
    end
    stall = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3100 || D_IR !== mem_word(32'h3004) ||
        D_NPC !== 32'h3008) begin
      failures++;
      $display("FAIL bfull_jump: req=%b addr=%h ir=%h npc=%h want 1 3100 %h 3008",
               imem_req, imem_addr, D_IR, D_NPC, mem_word(32'h3004));
    end
    drain("branch_full", 20);
  endtask

  task automatic test_wrap();
    do_reset();
    br_en  = 1'b1;
    br_pc  = 32'h3000;
    br_tgt = 32'hFFFF_FFFC;
    exp_fetch.push_back(32'h3000);
    exp_fetch.push_back(32'h3004);
    exp_fetch.push_back(32'hFFFF_FFFC);
    exp_fetch.push_back(32'h0000_0000);
    push_dec(32'h3000);
    push_dec(32'h3004);
    push_dec(32'hFFFF_FFFC);
    push_dec(32'h0000_0000);
    repeat (4) step();
    checks++;
    if (imem_addr !== 32'h0 || D_NPC !== 32'h0) begin
      failures++;
      $display("FAIL pc_wrap: addr=%h npc=%h want 0 0", imem_addr, D_NPC);
    end
    drain("wrap", 20);
  endtask

  task automatic test_reset_mid();
    do_reset();
    exp_fetch.push_back(32'h3000);
    exp_fetch.push_back(32'h3004);
    push_dec(32'h3000);
    push_dec(32'h3004);
    repeat (3) step();
    lat = 100;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin
      failures++;
      $display("FAIL mid_req: req=%b addr=%h want 1 3008", imem_req, imem_addr);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== RPC || D_IR !== 32'h0 ||
        D_NPC !== 32'h0 || D_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: req=%b addr=%h ir=%h npc=%h v=%b want 0 %h 0 0 0",
               imem_req, imem_addr, D_IR, D_NPC, D_valid, RPC);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (D_valid !== 1'b0 || D_IR !== 32'h0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack: v=%b ir=%h req=%b want 0 0 0", D_valid, D_IR, imem_req);
    end
    imem_ack = 1'b0;
    rst      = 1'b1;
    lat      = 0;
    wait_cnt = 0;
    exp_fetch.delete();
    exp_dec.delete();
    exp_fetch.push_back(32'h3000);
    exp_fetch.push_back(32'h3004);
    push_dec(32'h3000);
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      failures++;
      $display("FAIL restart: req=%b addr=%h want 1 %h", imem_req, imem_addr, RPC);
    end
    drain("reset_mid", 20);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    stall    = 1'b0;
    br_en    = 1'b0;
    br_pc    = 32'h0;
    br_tgt   = 32'h0;
    test_reset();
    test_zero_wait();
    test_ack_wait();
    test_stall();
    test_branch_slot();
    test_branch_redir();
    test_branch_full();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
